// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt router: FSM states, class codes
// and the bit layout of the cause word.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Class codes; each selects one core request line.
    localparam logic [1:0] CLS_IRQ1 = 2'd0;
    localparam logic [1:0] CLS_IRQ2 = 2'd1;
    localparam logic [1:0] CLS_IRQ3 = 2'd2;

    // Cause word layout: {valid, missed, 10'b0, id[3:0]}.
    localparam int CAUSE_VALID  = 15;
    localparam int CAUSE_MISSED = 14;
    localparam int CAUSE_ID_MSB = 3;
    localparam int CAUSE_ID_LSB = 0;

    // Class code 3 has no line of its own and folds onto irq3.
    function automatic logic [1:0] norm_class(input logic [1:0] c);
        return (c == 2'd3) ? CLS_IRQ3 : c;
    endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational class-then-index priority select. Class 0 beats class 1
// beats class 2; inside a class the lowest source index wins.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int          NSRC      = 8,
    parameter logic [31:0] CLASS_MAP = 32'h0000_0000
) (
    input  logic [NSRC-1:0] req,
    output logic            hit,
    output logic [3:0]      id,
    output logic [1:0]      cls
);

    logic [NSRC-1:0] cls0_vec;
    logic [NSRC-1:0] cls1_vec;
    logic [NSRC-1:0] cls2_vec;

    // Split the request vector into one vector per class.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_split
            localparam logic [1:0] SRC_CLASS = norm_class(CLASS_MAP[2*gi +: 2]);
            assign cls0_vec[gi] = req[gi] && (SRC_CLASS == CLS_IRQ1);
            assign cls1_vec[gi] = req[gi] && (SRC_CLASS == CLS_IRQ2);
            assign cls2_vec[gi] = req[gi] && (SRC_CLASS == CLS_IRQ3);
        end
    endgenerate

    // Scan lowest priority first so the strongest class writes last; each
    // scan runs high-to-low so the lowest set index is the one that sticks.
    always_comb begin
        hit = 1'b0;
        id  = 4'd0;
        cls = CLS_IRQ1;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cls2_vec[i]) begin
                hit = 1'b1;
                id  = 4'(i);
                cls = CLS_IRQ3;
            end
        end
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cls1_vec[i]) begin
                hit = 1'b1;
                id  = 4'(i);
                cls = CLS_IRQ2;
            end
        end
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cls0_vec[i]) begin
                hit = 1'b1;
                id  = 4'(i);
                cls = CLS_IRQ1;
            end
        end
    end

endmodule

// File: rtl/irq_router.sv
// Interrupt router: rising-edge capture per source, class/index arbitration
// and a request/accept/return handshake with the core over irq1..3 and eirq.
// Optional macro IRQ_ROUTER_TIMEOUT_EN adds a request timeout that drops an
// unaccepted request and flags it in cause.missed.
module irq_router
    import irq_pkg::*;
#(
    parameter int          NSRC      = 8,
    parameter logic [31:0] CLASS_MAP = 32'h0000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_req,
    input  logic            cfg_we,
    input  logic [15:0]     cfg_data,
    input  logic            eirq,
    output logic            irq1,
    output logic            irq2,
    output logic            irq3,
    output logic [15:0]     cause,
    output logic            busy
);

    logic [NSRC-1:0] req_reg;
    logic [NSRC-1:0] mask_reg;
    logic [NSRC-1:0] pending_reg, pending_next;
    logic [NSRC-1:0] rise_vec;
    logic [NSRC-1:0] drop_vec;
    logic            eirq_reg;
    state_t          state_reg, state_next;
    logic [3:0]      id_reg, id_next;
    logic [1:0]      cls_reg, cls_next;
    logic [15:0]     cause_reg, cause_next;
    logic            drop;
    logic            eirq_rise, eirq_fall;
    logic            arb_hit;
    logic [3:0]      arb_id;
    logic [1:0]      arb_cls;
    logic            cfg_unused;

    // Mask bits at and above NSRC have no source behind them.
    assign cfg_unused = ^cfg_data;

    assign rise_vec  = src_req & ~req_reg & mask_reg;
    assign eirq_rise = eirq & ~eirq_reg;
    assign eirq_fall = ~eirq & eirq_reg;

    // One-hot clear of the held source when it is accepted or timed out.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_drop
            assign drop_vec[gi] = drop && (id_reg == 4'(gi));
        end
    endgenerate

    irq_arbiter #(
        .NSRC      (NSRC),
        .CLASS_MAP (CLASS_MAP)
    ) u_arb (
        .req (pending_reg & mask_reg),
        .hit (arb_hit),
        .id  (arb_id),
        .cls (arb_cls)
    );

`ifdef IRQ_ROUTER_TIMEOUT_EN
    logic [7:0] timer_reg;

    // Cycles spent in REQ; restarts whenever the FSM is elsewhere.
    always_ff @(posedge clk) begin
        if (!rst || state_reg != REQ) timer_reg <= 8'd0;
        else                          timer_reg <= timer_reg + 8'd1;
    end
`else
    logic [7:0] timeout_unused;
    assign timeout_unused = 8'(TIMEOUT);
`endif

    // Pending update: clears first, then new edges, so a same-cycle set wins.
    always_comb begin
        pending_next = pending_reg & ~drop_vec;
        if (cfg_we) pending_next = pending_next & cfg_data[NSRC-1:0];
        pending_next = pending_next | rise_vec;
    end

    // FSM next state, held request and cause word.
    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        cls_next   = cls_reg;
        cause_next = cause_reg;
        drop       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (arb_hit) begin
                    id_next    = arb_id;
                    cls_next   = arb_cls;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (eirq_rise) begin
                    drop       = 1'b1;
                    cause_next = 16'd0;
                    cause_next[CAUSE_VALID] = 1'b1;
                    cause_next[CAUSE_ID_MSB:CAUSE_ID_LSB] = id_reg;
                    state_next = SERV;
                end
`ifdef IRQ_ROUTER_TIMEOUT_EN
                else if (timer_reg == 8'(TIMEOUT - 1)) begin
                    drop       = 1'b1;
                    cause_next = 16'd0;
                    cause_next[CAUSE_MISSED] = 1'b1;
                    cause_next[CAUSE_ID_MSB:CAUSE_ID_LSB] = id_reg;
                    state_next = GAP;
                end
`endif
            end
            SERV: begin
                if (eirq_fall) state_next = GAP;
            end
            GAP: begin
                cause_next[CAUSE_VALID] = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, capture and configuration registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_reg     <= '0;
            eirq_reg    <= 1'b0;
            mask_reg    <= '1;
            pending_reg <= '0;
            state_reg   <= IDLE;
            id_reg      <= 4'd0;
            cls_reg     <= CLS_IRQ1;
            cause_reg   <= 16'd0;
        end else begin
            req_reg     <= src_req;
            eirq_reg    <= eirq;
            if (cfg_we) mask_reg <= cfg_data[NSRC-1:0];
            pending_reg <= pending_next;
            state_reg   <= state_next;
            id_reg      <= id_next;
            cls_reg     <= cls_next;
            cause_reg   <= cause_next;
        end
    end

    assign irq1  = (state_reg == REQ) && (cls_reg == CLS_IRQ1);
    assign irq2  = (state_reg == REQ) && (cls_reg == CLS_IRQ2);
    assign irq3  = (state_reg == REQ) && (cls_reg == CLS_IRQ3);
    assign busy  = (state_reg != IDLE);
    assign cause = cause_reg;

endmodule

// File: doc/irq_router.md
# irq_router

Interrupt source controller that drives the core's three request lines (`irq1`..`irq3`) and consumes its `eirq` in-service indicator. It sits between peripheral request lines and the core. It latches rising edges per source, arbitrates by class and index, and holds one request until the core accepts it. It also publishes a cause word for the core's input port so handlers can identify the source.

## Interface
Parameters:
- `NSRC`, 8: number of peripheral sources, 1..16.
- `CLASS_MAP`, 32'h0000_0000: 2 bits per source i at [2i+1:2i].
  - 0 → `irq1`, 1 → `irq2`, 2 → `irq3`; 3 is treated as 2.
- `TIMEOUT`, 255: request-to-accept limit in cycles, 1..255.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `src_req`  in  NSRC  peripheral request lines, level; rising edge = event.
- `cfg_we`  in  1  load enable mask.
- `cfg_data`  in  16  new mask; bit i enables source i; bits ≥ NSRC ignored.
- `eirq`  in  1  core in-service indicator; rising = accept, falling = handler return.
- `irq1`, `irq2`, `irq3`  out  1 each  requests to core; at most one high.
- `cause`  out  16  {valid, missed, 10'b0, id[3:0]} of the current or last serviced source.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Edge capture: `req_q` registers `src_req`.
  - Pending[i] sets when `src_req[i] & ~req_q[i] & mask[i]`.
  - Disabled sources never set pending.
  - Writing `cfg_we` clears pending bits whose mask bit goes to 0.
- Arbitration:
  - Class 0 beats class 1, which beats class 2.
  - Within a class, the lowest index wins.
  - The winner is chosen only in IDLE.
- FSM:
  - IDLE: if any pending, latch winner id/class, go to REQ; else stay.
  - REQ: assert the class line. On the `eirq` rising edge (`eirq & ~eirq_q`):
    - clear pending[id];
    - set `cause` = {1, 0, …, id};
    - go to SERV.
  - SERV: all irq lines low; wait for `eirq` falling edge, then go to GAP.
  - GAP: one cycle, lines low; set `cause.valid` = 0, retain id; go to IDLE.
- Simultaneous set and clear of the same pending bit in one cycle: set wins; the new event stays pending.
- New edges arriving during REQ/SERV/GAP are latched and never preempt. A higher class raised during REQ does not replace the held request.
- `eirq` already high on entry to REQ: no accept until it falls and rises again.
- Reset mid-operation: all outputs and state go to reset values in the cycle after `rst` is sampled low; an in-flight request is dropped.
- Reset values:
  - `irq1..3` = 0, `cause` = 0, `busy` = 0;
  - pending = 0, mask = all ones, `req_q` = 0, `eirq_q` = 0, state IDLE.

## Timing
- `src_req[i]` first sampled high at edge k → pending[i] = 1 after edge k → irq line high after edge k+1. Latency is 2 cycles.
- `eirq` sampled rising at edge m → irq line low and `cause.valid` = 1 after edge m.
- `eirq` sampled falling at edge n → GAP after n, IDLE after n+1. The earliest next request is high after n+2.
- `cfg_we` takes effect on pending capture one cycle later (mask is registered).

## Configuration
- `IRQ_ROUTER_TIMEOUT_EN` defined:
  - an 8-bit counter runs in REQ.
  - If `TIMEOUT` cycles elapse without an accept:
    - drop the request and leave pending[id] cleared;
    - set `cause` = {0, 1, …, id};
    - go to GAP.
  - `cause.missed` clears on the next accept.
- Undefined: no counter; REQ waits indefinitely; `cause[14]` is tied 0.

## Structure
- Shared package `irq_pkg`:
  - state enum IDLE/REQ/SERV/GAP;
  - class encoding constants;
  - cause bit positions (VALID = 15, MISSED = 14, ID = 3:0).
- One sub-module, `irq_arbiter`: combinational class-then-index priority select over pending & mask, returning {hit, id, class}. The FSM, capture logic and counter live in `irq_router`.

## Test plan
- Reset with `NSRC` = 8 and all classes 0. Pulse `src_req[3]`:
  - `irq1` high 2 cycles after the edge.
  - Raise `eirq` → `irq1` low, `cause` = 16'h8003.
  - Drop `eirq` → `cause` = 16'h0003, `busy` low 2 cycles later.
- With `CLASS_MAP` giving source 1 class 2 and source 6 class 0, edge both in the same cycle → `irq1` for id 6 first; after its handler, `irq3` for id 1.
- Edge sources 2 and 5 (both class 1) together → id 2 serviced first, then id 5.
- Write `cfg_data` = 16'h00FB (source 2 masked), then edge source 2 → no irq, `busy` stays 0. Unmask and edge again → served.
- With `IRQ_ROUTER_TIMEOUT_EN`, `TIMEOUT` = 10, edge source 0 and never raise `eirq` → irq line drops after 10 cycles, `cause` = 16'h4000.
- Edge source 4, then drive `rst` low while in REQ → all outputs 0 next cycle. After release, no request reappears.
